// File: rtl/tcdm_bank_arbiter_if.sv
// Initiator-side bus of one TCDM bank: per-initiator request payload and
// per-initiator grant/response. The arbiter takes the slave modport and the
// initiators (or a bench) take the master modport.
//
// Handshake semantics: an initiator raises req[i] together with add/wen/wdata/be.
// The request is accepted in the cycle in which gnt[i] is high. Until then the
// initiator may keep, change or drop its request; there is no locking.
// A response is signalled by a one-cycle pulse on vld[i]. rdata[i] is
// meaningful only while vld[i] is high.
interface tcdm_bank_arbiter_if #(
  parameter int unsigned NumIn        = 4,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned BeWidth      = DataWidth / 8,
  parameter int unsigned AddrMemWidth = 12
);
  logic [NumIn-1:0]                   req;
  logic [NumIn-1:0][AddrMemWidth-1:0] add;
  logic [NumIn-1:0]                   wen;
  logic [NumIn-1:0][DataWidth-1:0]    wdata;
  logic [NumIn-1:0][BeWidth-1:0]      be;
  logic [NumIn-1:0]                   gnt;
  logic [NumIn-1:0]                   vld;
  logic [NumIn-1:0][DataWidth-1:0]    rdata;

  modport master (output req, add, wen, wdata, be, input gnt, vld, rdata);
  modport slave  (input req, add, wen, wdata, be, output gnt, vld, rdata);
endinterface

// File: rtl/tcdm_bank_arbiter.sv
// Shares one TCDM bank among NumIn initiators. Round-robin arbitration with a
// starvation override picks one winner per cycle and forwards its request to
// the bank. A {valid, index} delay line of RespLat stages routes each bank
// response back to the initiator that issued it.
module tcdm_bank_arbiter #(
  parameter int unsigned NumIn        = 4,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned BeWidth      = DataWidth / 8,
  parameter int unsigned AddrMemWidth = 12,
  parameter int unsigned RespLat      = 1,
  parameter int unsigned WriteRespOn  = 1,
  parameter int unsigned StarveLimit  = 15
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  tcdm_bank_arbiter_if.slave      ini,
  output logic                    req_o,
  input  logic                    gnt_i,
  output logic [AddrMemWidth-1:0] add_o,
  output logic                    wen_o,
  output logic [DataWidth-1:0]    wdata_o,
  output logic [BeWidth-1:0]      be_o,
  input  logic [DataWidth-1:0]    rdata_i
);
  localparam int unsigned IdxW = (NumIn > 1) ? $clog2(NumIn) : 1;
  localparam int unsigned CntW = (StarveLimit > 0) ? $clog2(StarveLimit + 1) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(StarveLimit);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumIn - 1);
  localparam logic            WrResp  = (WriteRespOn != 0);

  logic [IdxW-1:0] r_rr;
  logic [CntW-1:0] r_wait [NumIn];
  logic            r_pv   [RespLat];
  logic [IdxW-1:0] r_pidx [RespLat];

  logic [IdxW-1:0] w_win;
  logic            w_starved;
  logic            w_hs;
  logic            w_resp;

  // Winner: lowest-index starved requester, else first requester at/after r_rr
  always_comb begin
    int v_j;
    w_win     = '0;
    w_starved = 1'b0;
    v_j       = 0;
    if (StarveLimit > 0) begin
      for (int i = NumIn - 1; i >= 0; i--) begin
        if (ini.req[i] && (r_wait[i] == CntMax)) begin
          w_starved = 1'b1;
          w_win     = IdxW'(i);
        end
      end
    end
    if (!w_starved) begin
      // Scanning from the farthest offset down leaves the nearest requester.
      for (int k = NumIn - 1; k >= 0; k--) begin
        v_j = int'(r_rr) + k;
        if (v_j >= int'(NumIn)) v_j = v_j - int'(NumIn);
        if (ini.req[v_j]) w_win = IdxW'(v_j);
      end
    end
  end

  // Bank request, initiator grant and winner payload (zero when idle)
  always_comb begin
    req_o   = |ini.req;
    ini.gnt = '0;
    add_o   = '0;
    wen_o   = 1'b0;
    wdata_o = '0;
    be_o    = '0;
    if (req_o) begin
      ini.gnt[w_win] = gnt_i & ini.req[w_win];
      add_o          = ini.add[w_win];
      wen_o          = ini.wen[w_win];
      wdata_o        = ini.wdata[w_win];
      be_o           = ini.be[w_win];
    end
  end

  assign w_hs   = req_o & gnt_i;
  assign w_resp = w_hs & (~wen_o | WrResp);

  // Round-robin pointer moves just past the winner on every bank handshake
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr <= '0;
    end else if (w_hs) begin
      r_rr <= (w_win == LastIdx) ? '0 : w_win + 1'b1;
    end
  end

  // Per-initiator wait counters, saturating at StarveLimit
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NumIn; i++) begin
      if (rst_i || (StarveLimit == 0) || !ini.req[i] || ini.gnt[i]) begin
        r_wait[i] <= '0;
      end else if (r_wait[i] != CntMax) begin
        r_wait[i] <= r_wait[i] + 1'b1;
      end
    end
  end

  // Response valid delay line; reset drops everything in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < RespLat; s++) r_pv[s] <= 1'b0;
    end else begin
      r_pv[0] <= w_resp;
      for (int s = 1; s < RespLat; s++) r_pv[s] <= r_pv[s-1];
    end
  end

  // Response index delay line; only meaningful alongside r_pv
  always_ff @(posedge clk_i) begin
    r_pidx[0] <= w_win;
    for (int s = 1; s < RespLat; s++) r_pidx[s] <= r_pidx[s-1];
  end

  // Route the final stage back to its requester
  always_comb begin
    ini.vld = '0;
    if (r_pv[RespLat-1]) ini.vld[r_pidx[RespLat-1]] = 1'b1;
  end

  assign ini.rdata = {NumIn{rdata_i}};

endmodule

// File: tb/tb_tcdm_bank_arbiter.sv
// Bench for tcdm_bank_arbiter: four initiators, two-cycle bank latency,
// write responses enabled, starvation limit of three cycles.
module tb_tcdm_bank_arbiter;
  localparam int NI  = 4;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int AW  = 12;
  localparam int RL  = 2;
  localparam int WRO = 1;
  localparam int SL  = 3;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  tcdm_bank_arbiter_if #(.NumIn(NI), .DataWidth(DW), .BeWidth(BW), .AddrMemWidth(AW)) ifc ();

  logic          bank_req;
  logic          bank_gnt;
  logic [AW-1:0] bank_add;
  logic          bank_wen;
  logic [DW-1:0] bank_wdata;
  logic [BW-1:0] bank_be;
  logic [DW-1:0] bank_rdata;

  tcdm_bank_arbiter #(
    .NumIn(NI), .DataWidth(DW), .BeWidth(BW), .AddrMemWidth(AW),
    .RespLat(RL), .WriteRespOn(WRO), .StarveLimit(SL)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .ini     (ifc.slave),
    .req_o   (bank_req),
    .gnt_i   (bank_gnt),
    .add_o   (bank_add),
    .wen_o   (bank_wen),
    .wdata_o (bank_wdata),
    .be_o    (bank_be),
    .rdata_i (bank_rdata)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp;
  int n_bad;
  int m_cyc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, m_cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic drive(input logic [NI-1:0] req, input logic [NI-1:0] wen, input logic gnt);
    ifc.req  = req;
    ifc.wen  = wen;
    bank_gnt = gnt;
  endtask

  task automatic set_payload();
    for (int i = 0; i < NI; i++) begin
      ifc.add[i]   = AW'(12'h100 + 16 * i);
      ifc.wdata[i] = 32'hA000_0000 + DW'(i);
      ifc.be[i]    = BW'(4'b0001 << i);
    end
  endtask

  // ---------------- behavioural model + compare ----------------
  // Model state: rotating start index, cycles waited per initiator, and
  // exp_q[k] = vld_o expected k cycles from now.
  int               m_rr;
  int               m_wait [NI];
  bit               m_on;
  logic [NI-1:0]    exp_q[$];

  always @(negedge clk) begin
    int            w;
    logic          any;
    logic          hs;
    logic [NI-1:0] eg;
    logic [NI-1:0] ev;
    logic [NI-1:0] nv;
    if (m_on) begin
      any = |ifc.req;
      w   = -1;
      for (int i = 0; i < NI; i++)
        if (SL > 0 && w < 0 && ifc.req[i] && m_wait[i] == SL) w = i;
      for (int k = 0; k < NI; k++) begin
        int j;
        j = (m_rr + k) % NI;
        if (w < 0 && ifc.req[j]) w = j;
      end
      eg = '0;
      if (any && bank_gnt) eg[w] = 1'b1;
      ev = exp_q.pop_front();
      chk("gnt_o", 64'(ifc.gnt), 64'(eg));
      chk("req_o", 64'(bank_req), 64'(any));
      chk("vld_o", 64'(ifc.vld), 64'(ev));
      if (any) begin
        chk("add_o",   64'(bank_add),   64'(ifc.add[w]));
        chk("wen_o",   64'(bank_wen),   64'(ifc.wen[w]));
        chk("wdata_o", 64'(bank_wdata), 64'(ifc.wdata[w]));
        chk("be_o",    64'(bank_be),    64'(ifc.be[w]));
      end else begin
        chk("idle_payload", 64'({bank_add, bank_wen, bank_wdata, bank_be}), 64'(0));
      end
      for (int i = 0; i < NI; i++) chk("rdata_o", 64'(ifc.rdata[i]), 64'(bank_rdata));
      // advance to the state after the coming rising edge
      hs = any && bank_gnt;
      for (int i = 0; i < NI; i++) begin
        if (!ifc.req[i] || eg[i]) m_wait[i] = 0;
        else if (m_wait[i] < SL) m_wait[i]++;
      end
      nv = '0;
      if (hs) begin
        m_rr = (w + 1) % NI;
        if (!ifc.wen[w] || WRO != 0) nv[w] = 1'b1;
      end
      exp_q.push_back(nv);
    end
    if (rst) begin
      m_rr = 0;
      for (int i = 0; i < NI; i++) m_wait[i] = 0;
      exp_q.delete();
      for (int s = 0; s < RL; s++) exp_q.push_back('0);
      m_on = 1'b1;
    end
    m_cyc++;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- directed stimulus with literal expectations ----------------
  logic [NI-1:0] exp1 [8];
  int            vcnt;

  initial begin
    n_cmp = 0; n_bad = 0; m_cyc = 0; m_on = 1'b0; m_rr = 0;
    exp1 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    rst = 1'b1;
    bank_rdata = 32'h0;
    set_payload();
    drive('0, '0, 1'b0);
    step();
    step();
    rst = 1'b0;

    // Reset state: nothing requested, nothing returned
    look();
    chk("rst_vld", 64'(ifc.vld), 64'(0));
    chk("rst_gnt", 64'(ifc.gnt), 64'(0));
    chk("rst_req", 64'(bank_req), 64'(0));
    step();

    // All four request continuously: strict rotation, one response per grant
    drive(4'b1111, 4'b0000, 1'b1);
    vcnt = 0;
    for (int k = 0; k < 8 + RL; k++) begin
      if (k == 8) drive('0, '0, 1'b1);
      look();
      if (k < 8) chk("t1_gnt", 64'(ifc.gnt), 64'(exp1[k]));
      if (ifc.vld != '0) vcnt++;
      step();
    end
    chk("t1_vld_count", 64'(vcnt), 64'(8));

    // Read from port 2 at 0x010, bank answers 0xDEADBEEF
    bank_rdata = 32'hDEAD_BEEF;
    ifc.add[2] = 12'h010;
    drive(4'b0100, 4'b0000, 1'b1);
    look();
    chk("t2_gnt", 64'(ifc.gnt), 64'(4'b0100));
    chk("t2_add", 64'(bank_add), 64'(12'h010));
    step();
    drive('0, '0, 1'b1);
    for (int k = 1; k <= RL; k++) begin
      look();
      chk("t2_vld", 64'(ifc.vld), 64'((k == RL) ? 4'b0100 : 4'b0000));
      if (k == RL) chk("t2_rdata", 64'(ifc.rdata[2]), 64'(32'hDEAD_BEEF));
      step();
    end

    // Write from port 1 also answers
    drive(4'b0010, 4'b0010, 1'b1);
    look();
    chk("t3_gnt", 64'(ifc.gnt), 64'(4'b0010));
    chk("t3_wen", 64'(bank_wen), 64'(1));
    step();
    drive('0, '0, 1'b1);
    for (int k = 1; k <= RL; k++) begin
      look();
      chk("t3_vld", 64'(ifc.vld), 64'((k == RL) ? 4'b0010 : 4'b0000));
      step();
    end

    // Starvation: ports 1 and 2 wait three cycles, then lowest index first
    drive(4'b0110, 4'b0000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      look();
      chk("t4_gnt_blocked", 64'(ifc.gnt), 64'(0));
      step();
    end
    bank_gnt = 1'b1;
    look();
    chk("t4_first", 64'(ifc.gnt), 64'(4'b0010));
    step();
    look();
    chk("t4_second", 64'(ifc.gnt), 64'(4'b0100));
    step();
    drive('0, '0, 1'b1);
    step();
    step();

    // Reset with responses in flight: only port 0's response survives
    drive(4'b0001, 4'b0000, 1'b1);
    look();
    chk("t5_gnt0", 64'(ifc.gnt), 64'(4'b0001));
    step();
    drive(4'b1000, 4'b0000, 1'b1);
    look();
    chk("t5_gnt3", 64'(ifc.gnt), 64'(4'b1000));
    chk("t5_vld_a", 64'(ifc.vld), 64'(0));
    step();
    drive(4'b0010, 4'b0000, 1'b1);
    rst = 1'b1;
    look();
    chk("t5_gnt1", 64'(ifc.gnt), 64'(4'b0010));
    chk("t5_vld_b", 64'(ifc.vld), 64'(4'b0001));
    step();
    rst = 1'b0;
    drive('0, '0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      look();
      chk("t5_dropped", 64'(ifc.vld), 64'(0));
      step();
    end
    drive(4'b1111, 4'b0000, 1'b1);
    look();
    chk("t5_rr_reset", 64'(ifc.gnt), 64'(4'b0001));
    step();

    // Requests change while the bank stalls: no grant, then port 0 wins
    drive(4'b1000, 4'b0000, 1'b0);
    for (int k = 0; k < 2; k++) begin
      look();
      chk("t6_stall", 64'(ifc.gnt), 64'(0));
      step();
    end
    drive(4'b0001, 4'b0000, 1'b0);
    look();
    chk("t6_stall_b", 64'(ifc.gnt), 64'(0));
    step();
    bank_gnt = 1'b1;
    look();
    chk("t6_gnt", 64'(ifc.gnt), 64'(4'b0001));
    step();

    // Mixed burst with stalls, writes and one reset pulse
    for (int k = 0; k < 60; k++) begin
      for (int i = 0; i < NI; i++) begin
        ifc.add[i]   = AW'($urandom);
        ifc.wdata[i] = DW'($urandom);
        ifc.be[i]    = BW'($urandom);
      end
      drive(NI'($urandom_range(0, 15)), NI'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
      bank_rdata = DW'($urandom);
      rst = (k == 30);
      step();
    end
    rst = 1'b0;
    drive('0, '0, 1'b1);
    repeat (RL + 2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
